idct_block_collector: RTL and testbench



---
 rtl/idct_pkg.sv | 18 +
 rtl/idct_pingpong_ram.sv | 39 +++
 rtl/idct_block_collector.sv | 125 ++++++++++++
 tb/tb_idct_block_collector.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/idct_pkg.sv
// Shared constants and types for the IDCT output block collector.
// Covers block modes, block lengths and the sample type.
package idct_pkg;

    localparam logic MODE_4X4 = 1'b0;
    localparam logic MODE_8X8 = 1'b1;

    localparam int unsigned BLK_LEN_4 = 16;
    localparam int unsigned BLK_LEN_8 = 64;

    typedef logic signed [15:0] sample_t;

    // Index of the final sample of a block in the given mode.
    function automatic int unsigned last_idx(input logic mode);
        return (mode == MODE_8X8) ? (BLK_LEN_8 - 1) : (BLK_LEN_4 - 1);
    endfunction

endpackage

// File: rtl/idct_pingpong_ram.sv
// Two-bank sample buffer with one write port and one registered read port.
// The bank select is the MSB of the flat memory index.
module idct_pingpong_ram
    import idct_pkg::*;
#(
    parameter int unsigned DW = 16,
    parameter int unsigned AW = 6
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic          wr_bank,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic          rd_bank,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data
);

    localparam int unsigned DEPTH = 2 * (2 ** AW);

    logic [DW-1:0] mem [DEPTH];

    // Storage is not reset; only the read register is.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[{wr_bank, wr_addr}] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_data <= '0;
        end else begin
            rd_data <= mem[{rd_bank, rd_addr}];
        end
    end

endmodule

// File: rtl/idct_block_collector.sv
// Frames the serial sample stream into 4x4 / 8x8 blocks held in a ping-pong
// buffer and hands each complete block to a consumer via valid/done.
module idct_block_collector
    import idct_pkg::*;
#(
    parameter int unsigned DW = 16,
    parameter int unsigned AW = 6
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] din,
    input  logic          din_en,
    input  logic          din_mode,
    output logic          blk_valid,
    output logic          blk_mode,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data,
    input  logic          blk_done,
    output logic          frame_err,
    output logic          ovf
);

    logic [AW-1:0] wr_cnt, wr_cnt_nxt;
    logic          wr_bank, wr_bank_nxt;
    logic          rd_bank, rd_bank_nxt;
    logic          cur_mode, cur_mode_nxt;
    logic [1:0]    full, full_nxt;
    logic [1:0]    bank_mode, bank_mode_nxt;
    logic          frame_err_nxt;
    logic          ovf_nxt;
    logic          we;
    logic [AW-1:0] wr_addr;
    logic          eff_mode;
    logic          mismatch;

    always_comb begin
        wr_cnt_nxt    = wr_cnt;
        wr_bank_nxt   = wr_bank;
        rd_bank_nxt   = rd_bank;
        cur_mode_nxt  = cur_mode;
        full_nxt      = full;
        bank_mode_nxt = bank_mode;
        frame_err_nxt = 1'b0;
        ovf_nxt       = ovf;
        we            = 1'b0;
        wr_addr       = wr_cnt;

        // The first sample of a block defines its mode.
        eff_mode = (wr_cnt == '0) ? din_mode : cur_mode;
        mismatch = (wr_cnt != '0) && (din_mode != cur_mode);

        if (din_en) begin
            if (full[wr_bank]) begin
                ovf_nxt = 1'b1;
            end else begin
                we = 1'b1;
                if (mismatch) begin
                    // Abort the partial block; this sample restarts framing.
                    wr_addr       = '0;
                    wr_cnt_nxt    = AW'(1);
                    cur_mode_nxt  = din_mode;
                    frame_err_nxt = 1'b1;
                end else begin
                    cur_mode_nxt = eff_mode;
                    if (wr_cnt == AW'(last_idx(eff_mode))) begin
                        full_nxt[wr_bank]      = 1'b1;
                        bank_mode_nxt[wr_bank] = eff_mode;
                        wr_bank_nxt            = ~wr_bank;
                        wr_cnt_nxt             = '0;
                    end else begin
                        wr_cnt_nxt = wr_cnt + AW'(1);
                    end
                end
            end
        end

        // Write bank differs from read bank whenever both can change here.
        if (blk_done && full[rd_bank]) begin
            full_nxt[rd_bank] = 1'b0;
            rd_bank_nxt       = ~rd_bank;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_cnt    <= '0;
            wr_bank   <= 1'b0;
            rd_bank   <= 1'b0;
            cur_mode  <= MODE_4X4;
            full      <= '0;
            bank_mode <= '0;
            blk_valid <= 1'b0;
            blk_mode  <= 1'b0;
            frame_err <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            wr_cnt    <= wr_cnt_nxt;
            wr_bank   <= wr_bank_nxt;
            rd_bank   <= rd_bank_nxt;
            cur_mode  <= cur_mode_nxt;
            full      <= full_nxt;
            bank_mode <= bank_mode_nxt;
            blk_valid <= full_nxt[rd_bank_nxt];
            blk_mode  <= bank_mode_nxt[rd_bank_nxt];
            frame_err <= frame_err_nxt;
            ovf       <= ovf_nxt;
        end
    end

    idct_pingpong_ram #(
        .DW (DW),
        .AW (AW)
    ) u_ram (
        .clk     (clk),
        .rst     (rst),
        .we      (we),
        .wr_bank (wr_bank),
        .wr_addr (wr_addr),
        .wr_data (din),
        .rd_bank (rd_bank),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

endmodule

// File: tb/tb_idct_block_collector.sv
// Directed bench for idct_block_collector: reads are scoreboarded through a
// queue and checked by a separate monitor; status flags are checked inline.
module tb_idct_block_collector;
    import idct_pkg::*;

    localparam int unsigned DW = 16;
    localparam int unsigned AW = 6;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] din;
    logic          din_en;
    logic          din_mode;
    logic          blk_valid;
    logic          blk_mode;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data;
    logic          blk_done;
    logic          frame_err;
    logic          ovf;

    typedef struct {
        string name;
        int    value;
    } exp_t;

    exp_t exp_q[$];
    int   vectors     = 0;
    int   miscompares = 0;
    int   fe_pulses   = 0;
    logic rd_req      = 1'b0;
    logic mon_req;

    always #5 clk = ~clk;

    idct_block_collector #(.DW(DW), .AW(AW)) dut (
        .clk       (clk),
        .rst       (rst),
        .din       (din),
        .din_en    (din_en),
        .din_mode  (din_mode),
        .blk_valid (blk_valid),
        .blk_mode  (blk_mode),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .blk_done  (blk_done),
        .frame_err (frame_err),
        .ovf       (ovf)
    );

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Monitor: a read request captured at an edge is compared just after it.
    always @(posedge clk) begin
        mon_req = rd_req;
        #1;
        if (mon_req) begin
            if (exp_q.size() == 0) begin
                check("unexpected_read", 1, 0);
            end else begin
                exp_t e;
                int   act;
                e   = exp_q.pop_front();
                act = sample_t'(rd_data);
                check(e.name, act, e.value);
            end
        end
        if (frame_err) fe_pulses++;
    end

    task automatic send(input int v, input logic m, input logic done = 1'b0);
        din      = DW'(v);
        din_mode = m;
        din_en   = 1'b1;
        blk_done = done;
        @(negedge clk);
        din_en   = 1'b0;
        blk_done = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic read(input int addr, input int exp, input string name);
        exp_t e;
        e.name  = name;
        e.value = exp;
        exp_q.push_back(e);
        rd_addr = AW'(addr);
        rd_req  = 1'b1;
        @(negedge clk);
        rd_req  = 1'b0;
    endtask

    task automatic done();
        blk_done = 1'b1;
        @(negedge clk);
        blk_done = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst      = 1'b0;
        din      = '0;
        din_en   = 1'b0;
        din_mode = 1'b0;
        rd_addr  = '0;
        blk_done = 1'b0;
        idle(2);
        check("rst_blk_valid", int'(blk_valid), 0);
        check("rst_blk_mode",  int'(blk_mode), 0);
        check("rst_rd_data",   int'(rd_data), 0);
        check("rst_frame_err", int'(frame_err), 0);
        check("rst_ovf",       int'(ovf), 0);
        rst = 1'b1;
        idle(2);

        // 4x4 block, samples 1..16
        for (int i = 1; i <= 15; i++) send(i, MODE_4X4);
        check("t1_valid_early", int'(blk_valid), 0);
        send(16, MODE_4X4);
        check("t1_valid", int'(blk_valid), 1);
        check("t1_mode",  int'(blk_mode), 0);
        read(5, 6, "t1_rd5");
        done();
        check("t1_released", int'(blk_valid), 0);

        // 8x8 block, samples -32..31 with enable gaps
        for (int i = 0; i < 63; i++) begin
            send(i - 32, MODE_8X8);
            if (i % 5 == 0) idle(1);
        end
        check("t2_valid_early", int'(blk_valid), 0);
        send(31, MODE_8X8);
        check("t2_valid", int'(blk_valid), 1);
        check("t2_mode",  int'(blk_mode), 1);
        read(63, 31, "t2_rd63");
        read(0, -32, "t2_rd0");
        done();
        check("t2_released", int'(blk_valid), 0);

        // Back-to-back blocks with no consumer: third block overflows
        for (int i = 0; i < 16; i++) send(100 + i, MODE_4X4);
        for (int i = 0; i < 64; i++) send(200 + i, MODE_8X8);
        check("t3_ovf_before", int'(ovf), 0);
        check("t3_valid", int'(blk_valid), 1);
        check("t3_mode0", int'(blk_mode), 0);
        send(300, MODE_4X4);
        check("t3_ovf", int'(ovf), 1);
        read(3, 103, "t3_rd3");
        done();
        check("t3_valid_next", int'(blk_valid), 1);
        check("t3_mode1", int'(blk_mode), 1);
        read(10, 210, "t3_rd10");
        done();
        check("t3_empty", int'(blk_valid), 0);
        check("t3_ovf_sticky", int'(ovf), 1);

        // Mode change mid-block aborts the partial block
        for (int i = 1; i <= 7; i++) send(i, MODE_8X8);
        check("t4_fe_before", int'(frame_err), 0);
        send(99, MODE_4X4);
        check("t4_fe_pulse", int'(frame_err), 1);
        for (int i = 1; i <= 15; i++) begin
            send(1000 + i, MODE_4X4);
            if (i == 1) check("t4_fe_clear", int'(frame_err), 0);
        end
        check("t4_valid", int'(blk_valid), 1);
        check("t4_mode",  int'(blk_mode), 0);
        read(0, 99, "t4_rd0");
        read(15, 1015, "t4_rd15");
        done();

        // blk_done coincides with the last sample of the next block
        for (int i = 0; i < 16; i++) send(500 + i, MODE_4X4);
        check("t5_valid_a", int'(blk_valid), 1);
        for (int i = 0; i < 63; i++) send(600 + i, MODE_8X8);
        send(663, MODE_8X8, 1'b1);
        check("t5_valid_b", int'(blk_valid), 1);
        check("t5_mode_b",  int'(blk_mode), 1);
        read(63, 663, "t5_rd63");
        read(0, 600, "t5_rd0");
        done();
        check("t5_empty", int'(blk_valid), 0);

        // Reset with a full bank pending and a partial block in flight
        for (int i = 0; i < 64; i++) send(800 + i, MODE_8X8);
        check("t6_valid_pre", int'(blk_valid), 1);
        check("t6_mode_pre",  int'(blk_mode), 1);
        for (int i = 0; i < 10; i++) send(900 + i, MODE_8X8);
        rst = 1'b0;
        @(negedge clk);
        check("t6_rst_valid", int'(blk_valid), 0);
        check("t6_rst_mode",  int'(blk_mode), 0);
        check("t6_rst_data",  int'(rd_data), 0);
        check("t6_rst_fe",    int'(frame_err), 0);
        check("t6_rst_ovf",   int'(ovf), 0);
        rst = 1'b1;
        idle(1);
        for (int i = 0; i < 16; i++) send(700 + i, MODE_4X4);
        check("t6_valid", int'(blk_valid), 1);
        check("t6_mode",  int'(blk_mode), 0);
        read(15, 715, "t6_rd15");
        read(2, 702, "t6_rd2");
        done();
        idle(3);

        check("frame_err_pulses", fe_pulses, 1);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
